// File: rtl/aes_kat_bist_if.sv
// Vector ROM and lockstep core bus shared by the KAT BIST controller (master)
// and the ROM/cores under test (slave).
interface aes_kat_bist_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 3
);
    logic [ADDR_W-1:0]        vec_addr;
    logic [127:0]             vec_key;
    logic [127:0]             vec_pt;
    logic [127:0]             vec_ct;
    logic                     core_start;
    logic                     core_enc_dec;
    logic [127:0]             core_key_in;
    logic [127:0]             core_data_in;
    logic [NUM_CORES-1:0]     core_ready;
    logic [NUM_CORES*128-1:0] core_data_out;

    modport master (
        output vec_addr, core_start, core_enc_dec, core_key_in, core_data_in,
        input  vec_key, vec_pt, vec_ct, core_ready, core_data_out
    );
    modport slave (
        input  vec_addr, core_start, core_enc_dec, core_key_in, core_data_in,
        output vec_key, vec_pt, vec_ct, core_ready, core_data_out
    );
endinterface

// File: rtl/aes_kat_bist.sv
// Known-answer BIST controller: runs every ROM vector through NUM_CORES lockstep
// AES cores (encrypt pass, then decrypt pass) and reports pass/fail and latency.

// Per-core capture, timeout marking and worst-case latency tracking.
module aes_kat_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             sample,
    input  logic             to_mark,
    input  logic             chk,
    input  logic             enc,
    input  logic [CNT_W-1:0] cnt,
    input  logic             ready,
    input  logic [127:0]     dout,
    output logic             cap_nxt,
    output logic [127:0]     res,
    output logic             tout,
    output logic [CNT_W-1:0] lat_max_enc,
    output logic [CNT_W-1:0] lat_max_dec
);
    logic             cap;
    logic             grab;
    logic [CNT_W-1:0] lat;

    assign grab    = sample && ready && !cap;
    assign cap_nxt = cap || grab;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap         <= 1'b0;
            res         <= '0;
            tout        <= 1'b0;
            lat         <= '0;
            lat_max_enc <= '0;
            lat_max_dec <= '0;
        end else begin
            if (clr) begin
                lat_max_enc <= '0;
                lat_max_dec <= '0;
            end
            if (load) begin
                cap  <= 1'b0;
                tout <= 1'b0;
                lat  <= '0;
            end else if (grab) begin
                cap <= 1'b1;
                res <= dout;
                lat <= cnt;
            end else if (to_mark && !cap) begin
                tout <= 1'b1;
                lat  <= '1;
            end
            if (chk) begin
                if (enc && lat > lat_max_enc) lat_max_enc <= lat;
                if (!enc && lat > lat_max_dec) lat_max_dec <= lat;
            end
        end
    end
endmodule

module aes_kat_bist #(
    parameter int NUM_CORES = 2,
    parameter int NUM_VEC   = 8,
    parameter int ADDR_W    = 3,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 200,
    parameter int MASK_CYC  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bist_start,
    input  logic                       stop_on_fail,
    aes_kat_bist_if.master             bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [7:0]                 err_count,
    output logic [ADDR_W-1:0]          fail_vec,
    output logic                       fail_mode,
    output logic [NUM_CORES-1:0]       fail_core_mask,
    output logic [NUM_CORES*CNT_W-1:0] lat_max_enc,
    output logic [NUM_CORES*CNT_W-1:0] lat_max_dec
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]  MASK_C = CNT_W'(MASK_CYC);
    localparam logic [CNT_W-1:0]  TO_C   = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(NUM_VEC - 1);

    state_t                        state;
    logic [ADDR_W-1:0]             vec_addr;
    logic                          core_start;
    logic                          enc;
    logic [127:0]                  key_in, data_in, expected;
    logic [CNT_W-1:0]              cnt;
    logic                          stop_lat, has_fail;

    logic                          run_clr, load_st, chk_st, sample, to_mark, all_cap, fail_any;
    logic [NUM_CORES-1:0]          cap_nxt, tout, own_bad, fail;
    logic [NUM_CORES-1:0][127:0]   res;
    logic [3:0]                    nfail;
    logic [8:0]                    err_sum;
    logic [7:0]                    err_next;

    assign bus.vec_addr     = vec_addr;
    assign bus.core_start   = core_start;
    assign bus.core_enc_dec = enc;
    assign bus.core_key_in  = key_in;
    assign bus.core_data_in = data_in;

    assign run_clr  = (state == S_IDLE || state == S_DONE) && bist_start;
    assign load_st  = (state == S_LOAD);
    assign chk_st   = (state == S_CHECK);
    // ready is ignored for the first MASK_CYC WAIT cycles to skip stale ready
    assign sample   = (state == S_WAIT) && (cnt > MASK_C);
    assign all_cap  = &cap_nxt;
    assign to_mark  = (state == S_WAIT) && (cnt == TO_C) && !all_cap;
    assign fail_any = |fail;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        aes_kat_lane #(.CNT_W(CNT_W)) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr         (run_clr),
            .load        (load_st),
            .sample      (sample),
            .to_mark     (to_mark),
            .chk         (chk_st),
            .enc         (enc),
            .cnt         (cnt),
            .ready       (bus.core_ready[i]),
            .dout        (bus.core_data_out[128*i +: 128]),
            .cap_nxt     (cap_nxt[i]),
            .res         (res[i]),
            .tout        (tout[i]),
            .lat_max_enc (lat_max_enc[CNT_W*i +: CNT_W]),
            .lat_max_dec (lat_max_dec[CNT_W*i +: CNT_W])
        );
        assign own_bad[i] = tout[i] || (res[i] != expected);
        // cross-check only against a healthy core 0 so its failure cannot cascade
        if (i == 0) begin : g_gold
            assign fail[i] = own_bad[i];
        end else begin : g_peer
            assign fail[i] = own_bad[i] || (!own_bad[0] && res[i] != res[0]);
        end
    end

    always_comb begin
        nfail = '0;
        for (int i = 0; i < NUM_CORES; i++) nfail = nfail + {3'b000, fail[i]};
    end

    assign err_sum  = {1'b0, err_count} + {5'b00000, nfail};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            vec_addr       <= '0;
            core_start     <= 1'b0;
            enc            <= 1'b1;
            key_in         <= '0;
            data_in        <= '0;
            expected       <= '0;
            cnt            <= '0;
            stop_lat       <= 1'b0;
            has_fail       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_vec       <= '0;
            fail_mode      <= 1'b0;
            fail_core_mask <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: if (bist_start) begin
                    busy           <= 1'b1;
                    done           <= 1'b0;
                    pass           <= 1'b0;
                    err_count      <= '0;
                    fail_vec       <= '0;
                    fail_mode      <= 1'b0;
                    fail_core_mask <= '0;
                    has_fail       <= 1'b0;
                    stop_lat       <= stop_on_fail;
                    enc            <= 1'b1;
                    vec_addr       <= '0;
                    state          <= S_FETCH;
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    key_in     <= bus.vec_key;
                    data_in    <= enc ? bus.vec_pt : bus.vec_ct;
                    expected   <= enc ? bus.vec_ct : bus.vec_pt;
                    core_start <= 1'b1;
                    state      <= S_START;
                end
                S_START: begin
                    cnt   <= 1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (all_cap || cnt == TO_C) state <= S_CHECK;
                    else                        cnt   <= cnt + 1'b1;
                end
                S_CHECK: begin
                    err_count <= err_next;
                    if (fail_any && !has_fail) begin
                        has_fail       <= 1'b1;
                        fail_vec       <= vec_addr;
                        fail_mode      <= enc;
                        fail_core_mask <= fail;
                    end
                    if (fail_any && stop_lat) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end else if (vec_addr != LAST_C) begin
                        vec_addr <= vec_addr + 1'b1;
                        state    <= S_FETCH;
                    end else if (enc) begin
                        enc      <= 1'b0;
                        vec_addr <= '0;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_kat_bist.sv
// Randomized bench for aes_kat_bist: behavioural cores and ROM, with a
// run-level reference model predicting status, latency and run length.
module tb_aes_kat_bist;
    localparam int NC = 2, NV = 8, AW = 3, CW = 8, TO = 200, MC = 1;

    logic clk = 1'b0, rst_n = 1'b0, bist_start = 1'b0, stop_on_fail = 1'b0;
    logic busy, done, pass, fail_mode;
    logic [7:0] err_count;
    logic [AW-1:0] fail_vec;
    logic [NC-1:0] fail_core_mask;
    logic [NC*CW-1:0] lat_max_enc, lat_max_dec;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    aes_kat_bist_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus ();

    aes_kat_bist #(.NUM_CORES(NC), .NUM_VEC(NV), .ADDR_W(AW), .CNT_W(CW),
                   .TIMEOUT(TO), .MASK_CYC(MC)) dut (
        .clk(clk), .rst_n(rst_n), .bist_start(bist_start), .stop_on_fail(stop_on_fail),
        .bus(bus), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_vec(fail_vec), .fail_mode(fail_mode), .fail_core_mask(fail_core_mask),
        .lat_max_enc(lat_max_enc), .lat_max_dec(lat_max_dec)
    );

    // vector ROM with one cycle read latency
    logic [127:0] rom_key [NV], rom_pt [NV], rom_ct [NV];
    always @(posedge clk) begin
        bus.vec_key <= rom_key[bus.vec_addr];
        bus.vec_pt  <= rom_pt[bus.vec_addr];
        bus.vec_ct  <= rom_ct[bus.vec_addr];
    end

    // core configuration and behavioural cores
    int lat_e [NC], lat_d [NC];
    bit never_rdy [NC], hold_rdy [NC];
    int cor_core = -1, cor_vec = 0;
    bit cor_enc = 1'b0;
    logic [127:0] cres [NC];
    int cnt_c [NC], lim_c [NC];
    bit run_c [NC];

    function automatic logic [127:0] core_out(input int c, input logic [127:0] k, d, input bit e);
        logic [127:0] r;
        int idx;
        r = ~d;
        idx = -1;
        for (int i = 0; i < NV; i++)
            if (rom_key[i] == k && (e ? rom_pt[i] == d : rom_ct[i] == d)) begin
                idx = i;
                r = e ? rom_ct[i] : rom_pt[i];
            end
        if (c == cor_core && idx == cor_vec && e == cor_enc) r[0] = ~r[0];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (bus.core_start) begin
                cres[c]  <= core_out(c, bus.core_key_in, bus.core_data_in, bus.core_enc_dec);
                cnt_c[c] <= 1;
                run_c[c] <= 1'b1;
                lim_c[c] <= bus.core_enc_dec ? lat_e[c] : lat_d[c];
            end else if (run_c[c] && cnt_c[c] < 1000) begin
                cnt_c[c] <= cnt_c[c] + 1;
            end
        end
    end

    always_comb begin
        bus.core_ready    = '0;
        bus.core_data_out = '0;
        for (int c = 0; c < NC; c++) begin
            bus.core_ready[c] = hold_rdy[c] || (!never_rdy[c] && run_c[c] && cnt_c[c] >= lim_c[c]);
            bus.core_data_out[128*c +: 128] = cres[c];
        end
    end

    int cyc_busy = 0, n_start = 0;
    always @(negedge clk) begin
        if (busy) cyc_busy <= cyc_busy + 1;
        if (bus.core_start) n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: walks the 2*NV operations at the level of whole runs
    int e_err, e_fvec, e_starts, e_cycles;
    bit e_fmode, e_pass;
    logic [NC-1:0] e_mask;
    int e_le [NC], e_ld [NC];

    task automatic model(input bit stop);
        bit seen, halt;
        seen = 0; halt = 0;
        e_err = 0; e_fvec = 0; e_fmode = 0; e_mask = '0; e_starts = 0; e_cycles = 0;
        for (int c = 0; c < NC; c++) begin e_le[c] = 0; e_ld[c] = 0; end
        for (int m = 0; m < 2 && !halt; m++) begin
            for (int v = 0; v < NV && !halt; v++) begin
                bit enc, anyto;
                int w;
                logic [NC-1:0] bad;
                enc = (m == 0); anyto = 0; w = 0; bad = '0;
                e_starts++;
                for (int c = 0; c < NC; c++) begin
                    int l;
                    bit to;
                    l  = hold_rdy[c] ? MC + 1 : (enc ? lat_e[c] : lat_d[c]);
                    to = !hold_rdy[c] && (never_rdy[c] || l > TO);
                    if (to) begin anyto = 1; l = (1 << CW) - 1; end
                    else if (l > w) w = l;
                    bad[c] = to || (c == cor_core && v == cor_vec && enc == cor_enc);
                    if (enc && l > e_le[c]) e_le[c] = l;
                    if (!enc && l > e_ld[c]) e_ld[c] = l;
                end
                if (anyto) w = TO;
                e_cycles += 4 + w;
                if (bad != '0) begin
                    e_err += $countones(bad);
                    if (e_err > 255) e_err = 255;
                    if (!seen) begin seen = 1; e_fvec = v; e_fmode = enc; e_mask = bad; end
                    if (stop) halt = 1;
                end
            end
        end
        e_pass = (e_err == 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "/status"}, {busy, done, pass, fail_mode}, 4'b0);
        chk({name, "/err_count"}, err_count, 0);
        chk({name, "/fail_vec_mask"}, {fail_vec, fail_core_mask}, 0);
        chk({name, "/lat_max"}, {lat_max_enc, lat_max_dec}, 0);
        chk({name, "/bus_ctl"}, {bus.vec_addr, bus.core_start, bus.core_enc_dec}, {{AW{1'b0}}, 2'b01});
        chk({name, "/operands"}, bus.core_key_in | bus.core_data_in, 0);
    endtask

    task automatic run_and_check(input string name, input bit stop);
        int s0, b0;
        bit seen;
        model(stop);
        s0 = n_start; b0 = cyc_busy; seen = 0;
        @(negedge clk); stop_on_fail = stop; bist_start = 1'b1;
        @(negedge clk); stop_on_fail = 1'b0; bist_start = 1'b0;
        chk({name, "/busy_after_start"}, {busy, done}, 2'b10);
        // a second start while busy must be ignored
        repeat (2) @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk); bist_start = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({name, "/done_reached"}, seen, 1'b1);
        chk({name, "/busy_end"}, busy, 1'b0);
        chk({name, "/pass"}, pass, e_pass);
        chk({name, "/err_count"}, err_count, e_err);
        chk({name, "/fail_vec"}, fail_vec, e_fvec);
        chk({name, "/fail_mode"}, fail_mode, e_fmode);
        chk({name, "/fail_core_mask"}, fail_core_mask, e_mask);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s/lat_enc%0d", name, c), lat_max_enc[CW*c +: CW], e_le[c]);
            chk($sformatf("%s/lat_dec%0d", name, c), lat_max_dec[CW*c +: CW], e_ld[c]);
        end
        chk({name, "/core_starts"}, n_start - s0, e_starts);
        chk({name, "/busy_cycles"}, cyc_busy - b0, e_cycles);
    endtask

    task automatic set_nominal();
        for (int c = 0; c < NC; c++) begin
            lat_e[c] = 31; lat_d[c] = 43; never_rdy[c] = 0; hold_rdy[c] = 0;
        end
        cor_core = -1;
    endtask

    initial begin
        bit seen;
        rom_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        rom_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        rom_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 1; i < NV; i++) begin
            rom_key[i] = {$urandom, $urandom, $urandom, $urandom};
            rom_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
            rom_ct[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        set_nominal();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        run_and_check("nominal", 1'b0);

        cor_core = 1; cor_vec = 2; cor_enc = 1'b0;
        run_and_check("corrupt_v2_dec", 1'b0);

        set_nominal();
        never_rdy[1] = 1;
        run_and_check("timeout", 1'b0);
        run_and_check("timeout_stop", 1'b1);

        set_nominal();
        hold_rdy[0] = 1; hold_rdy[1] = 1;
        run_and_check("held_ready", 1'b0);

        // asynchronous reset in the WAIT phase of vector 5
        set_nominal();
        @(negedge clk); bist_start = 1'b1;
        @(negedge clk); bist_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.vec_addr == 3'd5) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("midrun/reached_vec5", seen, 1'b1);
        repeat (10) @(negedge clk);
        chk("midrun/in_wait", {busy, bus.vec_addr}, {1'b1, 3'd5});
        rst_n = 1'b0;
        #1;
        chk_reset("midrun_reset");
        @(negedge clk); rst_n = 1'b1;
        run_and_check("post_reset", 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NC; c++) begin
                lat_e[c]     = $urandom_range(MC + 1, 60);
                lat_d[c]     = $urandom_range(MC + 1, 60);
                never_rdy[c] = ($urandom_range(0, 5) == 0);
                hold_rdy[c]  = ($urandom_range(0, 5) == 0);
            end
            cor_core = $urandom_range(0, NC) - 1;
            cor_vec  = $urandom_range(0, NV - 1);
            cor_enc  = $urandom_range(0, 1);
            run_and_check($sformatf("random%0d", r), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_kat_bist.md
# aes_kat_bist

Synthesizable known-answer built-in self-test controller for the AES cores. It drives one shared key/data/start bus into NUM_CORES cores running in lockstep (for example `aes_core_fixed` and `aes_core_optimized`). It runs every vector from an external vector ROM, first in encrypt mode and then in decrypt mode. For each core it checks the result against the expected value and against core 0, measures latency, detects timeouts, and reports status registers. This moves the lab-bench cross-check into silicon so it can run as a power-on self-test.

## Interface
- NUM_CORES, 2, number of cores under test (1..8); core 0 is the cross-check golden.
- NUM_VEC, 8, number of vectors in the ROM.
- ADDR_W, 3, vector address width; NUM_VEC ≤ 2^ADDR_W.
- CNT_W, 8, latency counter width.
- TIMEOUT, 200, maximum WAIT cycles per operation; must be < 2^CNT_W − 1.
- MASK_CYC, 1, number of initial WAIT cycles during which core ready is ignored.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- bist_start  in  1  one-cycle start pulse.
- stop_on_fail  in  1  abort at the end of the first failing vector check; sampled at bist_start.
- vec_addr  out  ADDR_W  vector ROM address.
- vec_key / vec_pt / vec_ct  in  128 each  ROM data, valid one cycle after vec_addr.
- core_start  out  1  one-cycle start pulse to all cores.
- core_enc_dec  out  1  1 = encrypt, 0 = decrypt.
- core_key_in / core_data_in  out  128 each  operands held stable from LOAD until the next LOAD.
- core_ready  in  NUM_CORES  per-core ready.
- core_data_out  in  NUM_CORES*128  per-core result; core i occupies bits [128i+127:128i].
- busy / done / pass  out  1 each  run status.
- err_count  out  8  count of failing checks; saturates at 255.
- fail_vec  out  ADDR_W  vector index of the first failure.
- fail_mode  out  1  enc_dec value at the first failure.
- fail_core_mask  out  NUM_CORES  cores that failed at the first failing vector.
- lat_max_enc / lat_max_dec  out  NUM_CORES*CNT_W  per-core worst-case latency per mode.

## Operation
- States: IDLE, FETCH, LOAD, START, WAIT, CHECK, DONE.
- Entering a run: bist_start in IDLE or DONE clears all status and latency registers. It then sets busy=1, mode=encrypt, vec_addr=0, and moves to FETCH. bist_start while busy is ignored.
- FETCH: present vec_addr; wait one cycle.
- LOAD: register key_in = vec_key.
  - Encrypt: data_in = vec_pt, expected = vec_ct.
  - Decrypt: data_in = vec_ct, expected = vec_pt.
  - Clear per-core captured flags.
- START: core_start = 1 for this cycle only.
- WAIT: counter cnt = 1 on the first WAIT cycle, then increments each cycle.
  - For cnt > MASK_CYC, an uncaptured core with core_ready = 1 captures core_data_out and records latency = cnt.
  - When all cores are captured, go to CHECK.
  - At cnt = TIMEOUT with any core uncaptured, go to CHECK. Uncaptured cores are marked timed-out with latency all-ones.
- CHECK: core i fails on timeout, on result ≠ expected, or on result ≠ core 0 result. A core-0 failure does not cascade to other cores through the cross-check alone.
  - Each failing core increments err_count once per vector.
  - On the first failing vector only, record fail_vec, fail_mode and fail_core_mask.
  - Update lat_max for the current mode with the unsigned maximum.
  - Next state:
    - Failure with stop_on_fail latched → DONE.
    - More vectors remain → vec_addr+1, FETCH.
    - Last vector in encrypt mode → mode = decrypt, vec_addr = 0, FETCH.
    - Otherwise → DONE.
- DONE: busy = 0, done = 1, pass = (err_count == 0). These hold until the next bist_start or reset.

## Timing
- Reset values: all outputs 0; state IDLE. core_enc_dec resets to 1.
- Per-vector cost is 4 + W cycles, where W = WAIT cycles (FETCH, LOAD, START, CHECK each take 1).
- bist_start high on edge k: busy = 1 from k+1; first core_start at k+3.
- core_start is never high outside START. Operands are stable during START and all of WAIT.
- A core whose ready stays high from the previous operation is ignored through cnt = MASK_CYC.
- A core asserting ready at cnt = TIMEOUT is captured, not timed out.
- err_count saturates at 255 and never wraps.
- Asynchronous reset mid-run returns immediately to IDLE with reset values, with core_start = 0 at once. No partial status survives.

## Test plan
- Two behavioral cores, latency 31 encrypt / 43 decrypt, correct outputs, FIPS-197 C.1 vector plus the seven other vectors → done after 16 operations, pass = 1, err_count = 0, lat_max_enc = 31 and lat_max_dec = 43 per core.
- Core 1 corrupts bit 0 of its result on vector 2 decrypt only → err_count = 1, fail_vec = 2, fail_mode = 0, fail_core_mask = 2'b10, pass = 0.
- Core 1 never asserts ready, TIMEOUT = 200 → each operation takes 200 WAIT cycles, err_count = 16, lat_max_enc[core1] = 8'hFF.
- Same as the previous case with stop_on_fail = 1 → DONE after vector 0 encrypt, err_count = 1, fail_vec = 0, fail_mode = 1.
- Core ready held high continuously, MASK_CYC = 1 → captured at cnt = 2 on every operation; core_start pulses exactly 16 times.
- Reset pulsed during WAIT of vector 5, then bist_start → all outputs 0 after reset; the second run completes normally with pass = 1.
